// File: rtl/l1_mem_resp_if.sv
// Request/response bundle between an L1 miss initiator and the backing memory responder.
// Latency: none (wires only); the responder sets the request-to-response timing.
// Backpressure: initiator holds l1_mem_valid and the request fields until it sees mem_l1_valid.
interface l1_mem_resp_if;
   logic        l1_mem_valid;
   logic        l1_mem_store;
   logic [31:0] l1_mem_addr;
   logic [31:0] l1_mem_wdata;
   logic [31:0] mem_l1_rdata;
   logic        mem_l1_valid;
   logic        mem_busy;

   modport master (
      output l1_mem_valid, l1_mem_store, l1_mem_addr, l1_mem_wdata,
      input  mem_l1_rdata, mem_l1_valid, mem_busy
   );

   modport slave (
      input  l1_mem_valid, l1_mem_store, l1_mem_addr, l1_mem_wdata,
      output mem_l1_rdata, mem_l1_valid, mem_busy
   );
endinterface

// File: rtl/l1_mem_resp.sv
// Word-wide backing memory for the L1D miss path: one load/store at a time, single-cycle response pulse.
// Latency: response LATENCY cycles after the request is accepted; one request per LATENCY+1 cycles.
// Backpressure: requests are only taken in IDLE; mem_busy is high while one is in flight.
// Optional L1_MEM_RESP_BOUNDS_CHK_EN: out-of-range loads return 32'hDEAD_BEEF, out-of-range stores are dropped.
module l1_mem_resp #(
   parameter int MEM_WORDS = 1024,
   parameter int LATENCY   = 4
) (
   input logic          clk,
   input logic          rst,
   l1_mem_resp_if.slave bus
);

   localparam int AW = $clog2(MEM_WORDS);
   localparam int CW = $clog2(LATENCY) + 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
   localparam logic [31:0]   OOB_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            store_q, store_d;
   logic [AW-1:0]   widx_q, widx_d;
   logic [31:0]     wdata_q, wdata_d;
   logic            oob_q, oob_d;
   logic [31:0]     rdata_q, rdata_d;

   // Storage is zero at power-up and deliberately survives rst.
   logic [31:0]     mem_q [MEM_WORDS] = '{default: '0};

   logic [AW-1:0]   in_widx;
   logic            in_oob;
   logic            acc_store;
   logic [AW-1:0]   acc_widx;
   logic [31:0]     acc_wdata;
   logic            acc_oob;
   logic            mem_we;

   assign in_widx = bus.l1_mem_addr[AW+1:2];

`ifdef L1_MEM_RESP_BOUNDS_CHK_EN
   assign in_oob = |bus.l1_mem_addr[31:AW+2];
`else
   // Upper address bits alias into the array.
   assign in_oob = 1'b0;
`endif

   // Byte-offset bits (and the upper bits in the aliasing build) carry no meaning here.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.l1_mem_addr[31:AW+2], bus.l1_mem_addr[1:0]};

   // Next-state, request latch and the array access done on the edge that enters RESP.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      store_d   = store_q;
      widx_d    = widx_q;
      wdata_d   = wdata_q;
      oob_d     = oob_q;
      rdata_d   = '0;
      mem_we    = 1'b0;
      acc_store = store_q;
      acc_widx  = widx_q;
      acc_wdata = wdata_q;
      acc_oob   = oob_q;

      case (state_q)
         IDLE: begin
            if (bus.l1_mem_valid) begin
               store_d = bus.l1_mem_store;
               widx_d  = in_widx;
               wdata_d = bus.l1_mem_wdata;
               oob_d   = in_oob;
               cnt_d   = CNT_INIT;
               if (LATENCY == 1) begin
                  // Entering RESP straight away: the access uses the live request.
                  acc_store = bus.l1_mem_store;
                  acc_widx  = in_widx;
                  acc_wdata = bus.l1_mem_wdata;
                  acc_oob   = in_oob;
                  state_d   = RESP;
               end else begin
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (state_d == RESP && state_q != RESP) begin
         if (acc_store) begin
            mem_we = !acc_oob;
         end else begin
            rdata_d = acc_oob ? OOB_RDATA : mem_q[acc_widx];
         end
      end
   end

   // Control and response registers; reset drops any in-flight transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         store_q <= 1'b0;
         widx_q  <= '0;
         wdata_q <= '0;
         oob_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         store_q <= store_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
         oob_q   <= oob_d;
         rdata_q <= rdata_d;
      end
   end

   // Array write; held off while rst is high so a reset never lets a store commit.
   always_ff @(posedge clk) begin
      if (mem_we && !rst) begin
         mem_q[acc_widx] <= acc_wdata;
      end
   end

   assign bus.mem_l1_valid = (state_q == RESP);
   assign bus.mem_l1_rdata = rdata_q;
   assign bus.mem_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_l1_mem_resp.sv
module tb_l1_mem_resp;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   l1_mem_resp_if if0();
   l1_mem_resp_if if1();

   l1_mem_resp #(.MEM_WORDS(1024), .LATENCY(4)) dut0 (.clk(clk), .rst(rst), .bus(if0));
   l1_mem_resp #(.MEM_WORDS(1024), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   typedef struct {
      logic        store;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      logic        scramble;
   } vec_t;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One transaction on the LATENCY=4 instance, with latency, data and busy-length checks.
   task automatic txn(input vec_t v, input string tag);
      int lat;
      int busy_n;
      logic [31:0] rd;
      bit seen;
      @(posedge clk); #1;
      if0.l1_mem_valid = 1'b1;
      if0.l1_mem_store = v.store;
      if0.l1_mem_addr  = v.addr;
      if0.l1_mem_wdata = v.wdata;
      @(posedge clk); #1;
      if (v.scramble) begin
         if0.l1_mem_addr  = ~v.addr;
         if0.l1_mem_wdata = ~v.wdata;
         if0.l1_mem_store = ~v.store;
      end
      lat = 0; busy_n = 0; seen = 1'b0; rd = 32'hx;
      for (int n = 1; n <= 20 && !seen; n++) begin
         @(negedge clk);
         if (if0.mem_busy) busy_n++;
         if (if0.mem_l1_valid) begin
            seen = 1'b1;
            lat  = n;
            rd   = if0.mem_l1_rdata;
         end else if (n == 1) begin
            chk({tag, " idle_rdata"}, if0.mem_l1_rdata, 32'h0);
         end
      end
      chk({tag, " latency"}, lat, 4);
      chk({tag, " rdata"}, rd, v.exp);
      chk({tag, " busy_cycles"}, busy_n, 4);
      @(posedge clk); #1;
      if0.l1_mem_valid = 1'b0;
      if0.l1_mem_store = 1'b0;
      @(negedge clk);
      chk({tag, " after_valid"}, if0.mem_l1_valid, 1'b0);
      chk({tag, " after_busy"}, if0.mem_busy, 1'b0);
   endtask

   vec_t vecs[9];
   vec_t hv;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nhigh;
      bit seen;

      vecs[0] = '{1'b0, 32'h0000_0040, 32'h0,         32'h0000_0000, 1'b0};
      vecs[1] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
      vecs[2] = '{1'b0, 32'h0000_0013, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[3] = '{1'b1, 32'h0000_1004, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
`ifdef L1_MEM_RESP_BOUNDS_CHK_EN
      vecs[4] = '{1'b0, 32'h0000_1004, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[5] = '{1'b0, 32'h0000_0004, 32'h0,         32'h0000_0000, 1'b0};
`else
      vecs[4] = '{1'b0, 32'h0000_1004, 32'h0,         32'hA5A5_A5A5, 1'b0};
      vecs[5] = '{1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5, 1'b0};
`endif
      vecs[6] = '{1'b1, 32'h0000_0030, 32'h1111_2222, 32'h0000_0000, 1'b1};
      vecs[7] = '{1'b0, 32'h0000_0030, 32'h0,         32'h1111_2222, 1'b1};
      vecs[8] = '{1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0};

      if0.l1_mem_valid = 1'b0; if0.l1_mem_store = 1'b0;
      if0.l1_mem_addr  = '0;   if0.l1_mem_wdata = '0;
      if1.l1_mem_valid = 1'b0; if1.l1_mem_store = 1'b0;
      if1.l1_mem_addr  = '0;   if1.l1_mem_wdata = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset valid", if0.mem_l1_valid, 1'b0);
      chk("reset busy", if0.mem_busy, 1'b0);
      chk("reset rdata", if0.mem_l1_rdata, 32'h0);
      chk("reset1 valid", if1.mem_l1_valid, 1'b0);
      @(posedge clk); #1 rst = 1'b0;

      for (int i = 0; i < 9; i++) begin
         txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset in the second WAIT cycle: pending store must vanish.
      @(posedge clk); #1;
      if0.l1_mem_valid = 1'b1; if0.l1_mem_store = 1'b1;
      if0.l1_mem_addr  = 32'h20; if0.l1_mem_wdata = 32'h1234_5678;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      if0.l1_mem_valid = 1'b0; if0.l1_mem_store = 1'b0;
      @(negedge clk);
      chk("rst_wait busy", if0.mem_busy, 1'b0);
      chk("rst_wait valid", if0.mem_l1_valid, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      nhigh = 0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         if (if0.mem_l1_valid) nhigh++;
      end
      chk("rst_wait no_resp", nhigh, 0);
      hv = '{1'b0, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b0};
      txn(hv, "rst_wait load");

      // Reset during RESP: valid drops at once, committed store stays.
      @(posedge clk); #1;
      if0.l1_mem_valid = 1'b1; if0.l1_mem_store = 1'b1;
      if0.l1_mem_addr  = 32'h50; if0.l1_mem_wdata = 32'h5555_AAAA;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (if0.mem_l1_valid) seen = 1'b1;
      end
      chk("rst_resp seen", seen, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rst_resp valid", if0.mem_l1_valid, 1'b0);
      chk("rst_resp busy", if0.mem_busy, 1'b0);
      if0.l1_mem_valid = 1'b0; if0.l1_mem_store = 1'b0;
      @(posedge clk); #1 rst = 1'b0;
      hv = '{1'b0, 32'h0000_0050, 32'h0, 32'h5555_AAAA, 1'b0};
      txn(hv, "rst_resp load");

      // LATENCY=1, valid held: responses every other cycle.
      @(posedge clk); #1;
      if1.l1_mem_valid = 1'b1; if1.l1_mem_store = 1'b0; if1.l1_mem_addr = 32'h8;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("lat1 valid c%0d", c), if1.mem_l1_valid, (c % 2) == 1);
         chk($sformatf("lat1 busy c%0d", c), if1.mem_busy, (c % 2) == 1);
         chk($sformatf("lat1 rdata c%0d", c), if1.mem_l1_rdata, 32'h0);
      end
      @(posedge clk); #1;
      if1.l1_mem_valid = 1'b0;
      @(negedge clk);
      chk("lat1 last valid", if1.mem_l1_valid, 1'b1);
      @(negedge clk);
      chk("lat1 end valid", if1.mem_l1_valid, 1'b0);
      chk("lat1 end busy", if1.mem_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
